// File: rtl/acq_pkg.sv
// acq_pkg: shared state encoding and default widths for the acquisition sequencer
package acq_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} acq_state_t;
  localparam int WIN_W_DEF = 48;
  localparam int REC_W_DEF = 32;
  localparam int CLR_CYCLES_DEF = 4;
  localparam int DRAIN_CYC_DEF = 8;
endpackage

// File: rtl/acq_phase_timer.sv
// acq_phase_timer: loadable down-counter, tc high while the count sits at zero
module acq_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  output logic         tc
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= val;
    else if (cnt != '0) cnt <= cnt - W'(1);
  assign tc = cnt == '0;
endmodule

// File: rtl/acq_sequencer.sv
// acq_sequencer: acquisition run controller (IDLE/CLEAR/RUN/DRAIN/DONE); ACQ_REC_LIMIT_EN adds record-count stop
module acq_sequencer
  import acq_pkg::*;
#(
  parameter int WIN_W      = WIN_W_DEF,
  parameter int REC_W      = REC_W_DEF,
  parameter int CLR_CYCLES = CLR_CYCLES_DEF,
  parameter int DRAIN_CYC  = DRAIN_CYC_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [WIN_W-1:0] win_len,
`ifdef ACQ_REC_LIMIT_EN
  input  logic [REC_W-1:0] rec_limit,
`endif
  input  logic             data_rdy,
  output logic             operate,
  output logic             reset_counter,
  output logic             busy,
  output logic             done,
  output logic [REC_W-1:0] rec_count,
  output logic [WIN_W-1:0] elapsed
);
  localparam int TW = $clog2((CLR_CYCLES > DRAIN_CYC ? CLR_CYCLES : DRAIN_CYC) + 1);
  acq_state_t state, state_n;
  logic [WIN_W-1:0] win_q;
  logic [REC_W-1:0] rec_n;
  logic accept, rec_inc, win_end, hit_lim, tc, ld;
  logic [TW-1:0] ld_val;
  assign accept  = state == IDLE && start && !stop;
  assign rec_inc = data_rdy && (state == RUN || state == DRAIN);
  assign rec_n   = rec_inc && rec_count != '1 ? rec_count + REC_W'(1) : rec_count;
  assign win_end = win_q != '0 && elapsed == win_q - WIN_W'(1);
`ifdef ACQ_REC_LIMIT_EN
  logic [REC_W-1:0] lim_q;
  always_ff @(posedge clk)
    if (reset) lim_q <= '0;
    else if (accept) lim_q <= rec_limit;
  assign hit_lim = rec_inc && state == RUN && lim_q != '0 && rec_n == lim_q;
`else
  assign hit_lim = 1'b0;
`endif
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = accept ? CLEAR : IDLE;
      CLEAR:   state_n = stop ? DRAIN : tc ? RUN : CLEAR;
      RUN:     state_n = stop || win_end || hit_lim ? DRAIN : RUN;
      DRAIN:   state_n = tc ? DONE : DRAIN;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // phase timer reloads on entry to CLEAR or DRAIN so tc marks that phase's last cycle
  assign ld     = state_n != state && (state_n == CLEAR || state_n == DRAIN);
  assign ld_val = state_n == CLEAR ? TW'(CLR_CYCLES - 1) : TW'(DRAIN_CYC - 1);
  acq_phase_timer #(.W(TW)) u_timer (
    .clk (clk),
    .rst (reset),
    .load(ld),
    .val (ld_val),
    .tc  (tc)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state         <= IDLE;
      operate       <= 1'b0;
      reset_counter <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rec_count     <= '0;
      elapsed       <= '0;
      win_q         <= '0;
    end else begin
      state         <= state_n;
      operate       <= state_n == RUN;
      reset_counter <= state_n == CLEAR;
      busy          <= state_n != IDLE;
      done          <= state_n == DONE;
      if (accept) begin
        win_q     <= win_len;
        rec_count <= '0;
        elapsed   <= '0;
      end else begin
        rec_count <= rec_n;
        if (state == RUN && elapsed != '1) elapsed <= elapsed + WIN_W'(1);
      end
    end
endmodule

// File: tb/tb_acq_sequencer.sv
// tb_acq_sequencer: directed self-checking bench for acq_sequencer
module tb_acq_sequencer;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, stop = 1'b0, data_rdy = 1'b0;
  logic [47:0] win_len = '0;
  logic [31:0] rec_limit = '0;
  logic operate, reset_counter, busy, done;
  logic [31:0] rec_count;
  logic [47:0] elapsed;
  int tests = 0, fails = 0;
  int n_cyc = 0, n_clr = 0, n_op = 0, n_done = 0, fall_cyc = 0, done_cyc = 0;
  logic op_d = 1'b0;
  int s_clr, s_op, s_done;

  acq_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .win_len      (win_len),
`ifdef ACQ_REC_LIMIT_EN
    .rec_limit    (rec_limit),
`endif
    .data_rdy     (data_rdy),
    .operate      (operate),
    .reset_counter(reset_counter),
    .busy         (busy),
    .done         (done),
    .rec_count    (rec_count),
    .elapsed      (elapsed)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    n_cyc  <= n_cyc + 1;
    n_clr  <= n_clr + int'(reset_counter);
    n_op   <= n_op + int'(operate);
    n_done <= n_done + int'(done);
    if (op_d && !operate) fall_cyc <= n_cyc;
    if (done) done_cyc <= n_cyc;
    op_d <= operate;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic snap;
    @(negedge clk);
    #1;
    s_clr = n_clr;
    s_op = n_op;
    s_done = n_done;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    for (k = 0; k < budget && busy; k++) tick();
    chk({tag, "_idle_timeout"}, 64'(busy), 64'd0);
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_op(input string tag);
    int k;
    for (k = 0; k < 20 && !operate; k++) tick();
    chk({tag, "_op_rise"}, 64'(operate), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_operate", 64'(operate), 64'd0);
    chk("rst_rc", 64'(reset_counter), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rec", 64'(rec_count), 64'd0);
    chk("rst_elapsed", 64'(elapsed), 64'd0);

    // 1: fixed window of 100
    snap();
    win_len = 48'd100;
    pulse_start();
    chk("t1_clear_rc", 64'(reset_counter), 64'd1);
    chk("t1_clear_op", 64'(operate), 64'd0);
    wait_idle("t1", 400);
    chk("t1_clr_cycles", 64'(n_clr - s_clr), 64'd4);
    chk("t1_op_cycles", 64'(n_op - s_op), 64'd100);
    chk("t1_done_pulses", 64'(n_done - s_done), 64'd1);
    chk("t1_drain_gap", 64'(done_cyc - fall_cyc), 64'd8);
    chk("t1_elapsed", 64'(elapsed), 64'd100);
    chk("t1_rec", 64'(rec_count), 64'd0);

    // 2: open window ended by stop in the 37th RUN cycle
    snap();
    win_len = 48'd0;
    pulse_start();
    wait_op("t2");
    repeat (36) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t2_op_after_stop", 64'(operate), 64'd0);
    chk("t2_busy_drain", 64'(busy), 64'd1);
    wait_idle("t2", 100);
    chk("t2_op_cycles", 64'(n_op - s_op), 64'd37);
    chk("t2_elapsed", 64'(elapsed), 64'd37);
    chk("t2_done_pulses", 64'(n_done - s_done), 64'd1);

    // 3: records counted in RUN and DRAIN only
    snap();
    win_len = 48'd20;
    data_rdy = 1'b1;
    pulse_start();
    wait_op("t3");
    chk("t3_rec_first_run", 64'(rec_count), 64'd0);
    begin
      int k;
      for (k = 0; k < 40 && operate; k++) tick();
    end
    chk("t3_rec_run_end", 64'(rec_count), 64'd20);
    repeat (3) tick();
    data_rdy = 1'b0;
    wait_idle("t3", 100);
    chk("t3_rec", 64'(rec_count), 64'd23);
    chk("t3_op_cycles", 64'(n_op - s_op), 64'd20);

    // 4: start&stop in IDLE, then start while busy
    snap();
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("t4_ss_busy", 64'(busy), 64'd0);
    chk("t4_ss_rc", 64'(reset_counter), 64'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t4_stop_idle_busy", 64'(busy), 64'd0);
    win_len = 48'd10;
    pulse_start();
    chk("t4_busy", 64'(busy), 64'd1);
    tick();
    win_len = 48'd50;
    pulse_start();
    wait_op("t4");
    pulse_start();
    wait_idle("t4", 200);
    chk("t4_op_cycles", 64'(n_op - s_op), 64'd10);
    chk("t4_elapsed", 64'(elapsed), 64'd10);
    chk("t4_done_pulses", 64'(n_done - s_done), 64'd1);

    // window of one cycle
    snap();
    win_len = 48'd1;
    pulse_start();
    wait_idle("t4b", 100);
    chk("t4b_op_cycles", 64'(n_op - s_op), 64'd1);
    chk("t4b_elapsed", 64'(elapsed), 64'd1);

    // 5: reset in the middle of RUN
    snap();
    win_len = 48'd0;
    pulse_start();
    data_rdy = 1'b1;
    wait_op("t5");
    repeat (5) tick();
    chk("t5_rec_mid", 64'(rec_count), 64'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    data_rdy = 1'b0;
    chk("t5_operate", 64'(operate), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_rc", 64'(reset_counter), 64'd0);
    chk("t5_rec", 64'(rec_count), 64'd0);
    chk("t5_elapsed", 64'(elapsed), 64'd0);
    repeat (20) tick();
    chk("t5_no_done", 64'(n_done - s_done), 64'd0);

`ifdef ACQ_REC_LIMIT_EN
    // 6: record limit of 5 with a pulse every third RUN cycle
    snap();
    win_len = 48'd1000;
    rec_limit = 32'd5;
    pulse_start();
    wait_op("t6");
    begin
      int p = 0;
      for (int k = 1; k <= 30 && p < 5; k++) begin
        data_rdy = (k % 3) == 0;
        if (data_rdy) p++;
        tick();
      end
    end
    data_rdy = 1'b0;
    chk("t6_op_fall", 64'(operate), 64'd0);
    wait_idle("t6", 100);
    chk("t6_rec", 64'(rec_count), 64'd5);
    chk("t6_elapsed", 64'(elapsed), 64'd15);
    chk("t6_done_pulses", 64'(n_done - s_done), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
